accu_avg_buf: RTL

Downstream consumer of the `accu` group-sum stage. Accepts 10-bit group sums (each the sum of four 8-bit samples) over a valid/ready handshake and buffers them in a small FIFO. It emits each sum's rounded 8-bit average over a second valid/ready handshake. This decouples the accumulator from a slow sink, so `accu` stalls only when the buffer is full.

---
 rtl/accu_avg_buf.sv | 84 ++++++++
 1 files changed

// File: rtl/accu_avg_buf.sv
// accu_avg_buf: small FIFO behind the accu group-sum stage. It emits the
// rounded 8-bit average (sum/4, half up) of the head entry over valid/ready.
module accu_avg_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  data_in,
  input  logic        valid_a,
  output logic        ready_a,
  output logic        valid_b,
  input  logic        ready_b,
  output logic [7:0]  data_out,
  output logic [AW:0] fifo_cnt,
  output logic [7:0]  grp_cnt
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    grp_q, grp_d;
  logic          push, pop;
  logic [10:0]   rounded;

  // Full depends on the count alone, so a pop from full never opens a slot
  // in the same cycle. This keeps ready_a free of any path from ready_b.
  assign ready_a = (cnt_q != FULL);
  assign valid_b = (cnt_q != '0);
  assign push    = valid_a & ready_a;
  assign pop     = valid_b & ready_b;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    grp_d = grp_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop) begin
      rp_d  = rp_q + 1'b1;
      grp_d = grp_q + 8'd1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the pre-edge values and there is no order dependence between blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      grp_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      grp_q <= grp_d;
    end
  end

  // NOTE: the storage array is deliberately not reset. The pointers and the
  // count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= data_in;
  end

  // An 11-bit intermediate keeps the +2 rounding term from overflowing.
  // The largest sum, 1020, maps to 255.
  assign rounded  = {1'b0, mem_q[rp_q]} + 11'd2;
  assign data_out = 8'(rounded >> 2);
  assign fifo_cnt = cnt_q;
  assign grp_cnt  = grp_q;

endmodule
